// File: rtl/srl16_fifo_ctrl.sv
// Control and registered output stage for a shallow FIFO built from a bank of
// SRLC16E shift registers: generates CE/address, tracks occupancy, drives M side.
module srl16_fifo_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int AF_THR = 12,
    parameter int AE_THR = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             S_VALID,
    output logic             S_READY,
    output logic             SRL_CE,
    output logic [3:0]       SRL_ADDR,
    input  logic [WIDTH-1:0] SRL_Q,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [WIDTH-1:0] M_DATA,
    output logic [4:0]       LEVEL,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY
);

    localparam logic [4:0] DEPTH_L = 5'(DEPTH);
    localparam logic [4:0] AF_L    = 5'(AF_THR);
    localparam logic [4:0] AE_L    = 5'(AE_THR);

    logic [4:0]       srl_cnt_q, srl_cnt_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q,  m_data_d;
    logic             push, load, cnt_nz;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            srl_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            srl_cnt_q <= srl_cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Next state: SRL_Q is sampled pre-edge, so a simultaneous push cannot disturb the load
    always_comb begin
        srl_cnt_d = srl_cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (CLR) begin
            srl_cnt_d = '0;
            m_valid_d = 1'b0;
        end else begin
            if (load) begin
                m_data_d  = SRL_Q;
                m_valid_d = 1'b1;
            end else if (m_valid_q && M_READY) begin
                m_valid_d = 1'b0;
            end
            srl_cnt_d = srl_cnt_q + {4'd0, push} - {4'd0, load};
        end
    end

    // Outputs and handshake qualifiers; the oldest SRL entry always sits at srl_cnt-1
    always_comb begin
        cnt_nz       = (srl_cnt_q != 5'd0);
        S_READY      = RST_N & ~CLR & (srl_cnt_q != DEPTH_L);
        push         = S_VALID & S_READY;
        load         = ~CLR & cnt_nz & (~m_valid_q | M_READY);
        SRL_CE       = push;
        SRL_ADDR     = cnt_nz ? 4'(srl_cnt_q - 5'd1) : 4'd0;
        LEVEL        = srl_cnt_q + {4'd0, m_valid_q};
        ALMOST_FULL  = (LEVEL >= AF_L);
        ALMOST_EMPTY = (LEVEL <= AE_L);
        M_VALID      = m_valid_q;
        M_DATA       = m_data_q;
    end

endmodule

// File: tb/tb_srl16_fifo_ctrl.sv
// Self-checking bench: SRLC16E bank model plus a queue-based FIFO reference,
// directed test-plan sequences followed by randomized traffic.
module tb_srl16_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             CLK = 1'b0;
    logic             RST_N, CLR, S_VALID, M_READY;
    logic             S_READY, SRL_CE, M_VALID, ALMOST_FULL, ALMOST_EMPTY;
    logic [3:0]       SRL_ADDR;
    logic [WIDTH-1:0] SRL_Q, M_DATA, s_data;
    logic [4:0]       LEVEL;

    srl16_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THR(12), .AE_THR(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .S_VALID(S_VALID), .S_READY(S_READY),
        .SRL_CE(SRL_CE), .SRL_ADDR(SRL_ADDR), .SRL_Q(SRL_Q), .M_VALID(M_VALID),
        .M_READY(M_READY), .M_DATA(M_DATA), .LEVEL(LEVEL),
        .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY)
    );

    always #5 CLK = ~CLK;

    // SRLC16E bank: shift in D on CE, Q reads the addressed tap
    logic [WIDTH-1:0] srl_mem [16];
    always @(posedge CLK) begin
        if (SRL_CE) begin
            for (int i = 15; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
            srl_mem[0] <= s_data;
        end
    end
    assign SRL_Q = srl_mem[SRL_ADDR];

    // Reference: entries waiting in the SRL (oldest first) plus the output register
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] sb[$];
    logic             mv;
    logic [WIDTH-1:0] md;
    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at posedge+1: drive inputs, check outputs at posedge+2, advance one edge
    task automatic step(input logic v, input logic [7:0] d, input logic mr, input logic c);
        int   sz, lvl;
        logic exp_rdy, exp_push, exp_load;
        logic [WIDTH-1:0] exp_word;
        S_VALID = v; s_data = d; M_READY = mr; CLR = c;
        #1;
        sz       = q.size();
        lvl      = sz + int'(mv);
        exp_rdy  = !c && (sz != DEPTH);
        exp_push = v && exp_rdy;
        exp_load = !c && (sz != 0) && (!mv || mr);
        check_val("s_ready",   32'(S_READY),      32'(exp_rdy));
        check_val("srl_ce",    32'(SRL_CE),       32'(exp_push));
        check_val("m_valid",   32'(M_VALID),      32'(mv));
        check_val("m_data",    32'(M_DATA),       32'(md));
        check_val("level",     32'(LEVEL),        32'(lvl));
        check_val("almost_full",  32'(ALMOST_FULL),  32'(lvl >= 12));
        check_val("almost_empty", 32'(ALMOST_EMPTY), 32'(lvl <= 2));
        check_val("srl_addr",  32'(SRL_ADDR),     32'((sz == 0) ? 0 : sz - 1));
        check_val("level_bound", 32'(LEVEL <= 5'(DEPTH + 1)), 32'd1);
        if (M_VALID && mr && !c) begin
            check_val("order_avail", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_word = sb.pop_front();
                check_val("order", 32'(M_DATA), 32'(exp_word));
                $display("pop %0d data 0x%02h level %0d", n_pops, M_DATA, LEVEL);
                n_pops++;
            end
        end
        @(posedge CLK);
        #1;
        if (c) begin
            q.delete();
            sb.delete();
            mv = 1'b0;
        end else begin
            if (exp_load) begin
                md = q.pop_front();
                mv = 1'b1;
            end else if (mv && mr) begin
                mv = 1'b0;
            end
            if (exp_push) begin
                q.push_back(d);
                sb.push_back(d);
            end
        end
    endtask

    // Called at posedge+1: reset asserted mid-cycle, checked before any edge
    task automatic async_reset();
        #3;
        RST_N = 1'b0;
        #1;
        q.delete(); sb.delete(); mv = 1'b0; md = '0;
        check_val("rst_s_ready", 32'(S_READY), 32'd0);
        check_val("rst_m_valid", 32'(M_VALID), 32'd0);
        check_val("rst_level",   32'(LEVEL),   32'd0);
        check_val("rst_m_data",  32'(M_DATA),  32'd0);
        check_val("rst_srl_ce",  32'(SRL_CE),  32'd0);
        @(posedge CLK);
        #1;
        check_val("rst_hold_level", 32'(LEVEL), 32'd0);
        S_VALID = 1'b0; M_READY = 1'b0; CLR = 1'b0;
        RST_N = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        RST_N = 1'b0; CLR = 1'b0; S_VALID = 1'b1; M_READY = 1'b0; s_data = 8'h00;
        mv = 1'b0; md = '0;
        #1;
        check_val("init_s_ready", 32'(S_READY), 32'd0);
        check_val("init_m_valid", 32'(M_VALID), 32'd0);
        check_val("init_level",   32'(LEVEL),   32'd0);
        check_val("init_srl_ce",  32'(SRL_CE),  32'd0);
        repeat (2) @(posedge CLK);
        #1;
        check_val("init_m_data", 32'(M_DATA), 32'd0);
        S_VALID = 1'b0;
        RST_N = 1'b1;

        // Single word: two edges from push to M_VALID, then pop back to empty
        $display("test single_word");
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("single_m_data", 32'(M_DATA), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to 17 with consumer stalled, then drain in order
        $display("test fill_drain");
        for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check_val("fill_level", 32'(LEVEL),    32'd17);
        check_val("fill_addr",  32'(SRL_ADDR), 32'd15);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        drain(18);

        // Streaming: one in, one out per cycle
        $display("test streaming");
        for (int i = 0; i < 100; i++) step(1'b1, 8'(i + 8'h20), 1'b1, 1'b0);
        check_val("stream_level", 32'(LEVEL),   32'd2);
        check_val("stream_valid", 32'(M_VALID), 32'd1);
        drain(4);

        // Full boundary: single M_READY pulse admits exactly one push
        $display("test full_boundary");
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
        step(1'b1, 8'h80, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(i + 8'h81), 1'b0, 1'b0);
        check_val("full_level", 32'(LEVEL), 32'd17);
        drain(20);

        // CLR at LEVEL 9 with a push pending, then 0x3C must come out first
        $display("test clr");
        for (int i = 0; i < 9; i++) step(1'b1, 8'(i + 8'h60), 1'b0, 1'b0);
        check_val("clr_pre_level", 32'(LEVEL), 32'd9);
        step(1'b1, 8'h55, 1'b0, 1'b1);
        check_val("clr_post_level", 32'(LEVEL), 32'd0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("clr_first_word", 32'(M_DATA), 32'h3C);
        drain(3);

        // Async reset with LEVEL 5
        $display("test async_reset");
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 8'h70), 1'b0, 1'b0);
        check_val("ar_pre_level", 32'(LEVEL), 32'd5);
        async_reset();
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        drain(2);

        // Randomized traffic with occasional flush and reset
        $display("test random");
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 499) == 0) async_reset();
            step(1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 79) == 0));
        end
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/srl16_fifo_ctrl.md
Name: srl16_fifo_ctrl

Overview:
- Control and output stage for a shallow FIFO built from a bank of WIDTH parallel SRLC16E primitives.
- Push data drives the SRL D pins directly. This block generates the shared SRL CE and A3..A0, tracks occupancy, and captures the oldest SRL entry into a registered output stage with valid/ready handshake.
- Total capacity is DEPTH entries in the SRL plus 1 in the output register.
- Used wherever the design needs a small, LUT-cheap elastic buffer.

Parameters:
- WIDTH, 8, data width; must equal the number of SRLC16E instances, one per bit.
- DEPTH, 16, maximum SRL occupancy, legal range 2..16.
- AF_THR, 12, ALMOST_FULL asserts when LEVEL >= AF_THR.
- AE_THR, 2, ALMOST_EMPTY asserts when LEVEL <= AE_THR.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous flush, active high.
- S_VALID  in  1  push request; data is on the SRL D pins, externally wired.
- S_READY  out  1  push accepted this cycle when S_VALID & S_READY.
- SRL_CE  out  1  drives CE of every SRLC16E in the bank.
- SRL_ADDR  out  4  drives {A3,A2,A1,A0} of every SRLC16E.
- SRL_Q  in  WIDTH  Q outputs of the SRL bank.
- M_VALID  out  1  M_DATA holds a valid entry.
- M_READY  in  1  consumer accepts M_DATA when M_VALID & M_READY.
- M_DATA  out  WIDTH  registered oldest entry.
- LEVEL  out  5  total entries held, 0..DEPTH+1.
- ALMOST_FULL  out  1  LEVEL >= AF_THR.
- ALMOST_EMPTY  out  1  LEVEL <= AE_THR.

Behaviour:
- Internal state:
  - srl_cnt, 5 bits, range 0..DEPTH.
  - M_VALID register.
  - M_DATA register.
- Reset (RST_N low, async):
  - srl_cnt = 0, M_VALID = 0, M_DATA = 0.
  - S_READY = 0 while RST_N is low; 1 from the first cycle after release.
  - SRL contents are not cleared and are don't-care.
- S_READY = RST_N & ~CLR & (srl_cnt != DEPTH). Combinational from registers and CLR only, never from S_VALID.
- push = S_VALID & S_READY. SRL_CE = push, combinational. The SRL shifts in its D at the same edge.
- SRL_ADDR = srl_cnt-1 when srl_cnt != 0, else 0. The oldest SRL entry is always at address srl_cnt-1.
- load = ~CLR & (srl_cnt != 0) & (~M_VALID | M_READY).
  - On load: M_DATA <= SRL_Q, sampled pre-edge, so it is correct even with a simultaneous push. M_VALID <= 1.
- M_VALID & M_READY with no load: M_VALID <= 0; M_DATA holds its value.
- Count update: srl_cnt <= srl_cnt + push - load.
  - Simultaneous push and load leaves the count unchanged while the address stays stable.
- CLR (priority over everything except reset): srl_cnt <= 0, M_VALID <= 0, no push, no load. M_DATA holds its value.
- Derived FSM, reported only through the outputs:
  - EMPTY (srl_cnt=0, !M_VALID)
  - PRIMED (srl_cnt=0, M_VALID)
  - STREAM (0<srl_cnt<DEPTH)
  - FULL (srl_cnt=DEPTH)
  - EMPTY->PRIMED needs one load. FULL->STREAM needs one load without a push.
- Latency: a push accepted at edge k into an empty FIFO appears as M_VALID=1 after edge k+1, i.e. 2 cycles from S_VALID to M_VALID. No combinational path from S to M.
- Throughput: 1 push and 1 pop per cycle in steady state, with no bubbles while srl_cnt>0.
- LEVEL = srl_cnt + M_VALID. ALMOST_FULL and ALMOST_EMPTY are combinational from LEVEL.
- Boundaries:
  - Push when srl_cnt=DEPTH is impossible because S_READY=0.
  - With S_READY=0, M_VALID=1 and M_READY=1 at full, the edge loads, so S_READY=1 in the next cycle.
  - srl_cnt never wraps; values above DEPTH are unreachable and a bench assertion checks this.
  - M_READY asserted while M_VALID=0 has no effect.
  - RST_N asserted mid-burst immediately clears M_VALID and S_READY. Entries in flight are lost.

Test Plan:
- Reset then single word: push 0xA5 at cycle 0 -> SRL_CE=1 for 1 cycle; M_VALID=1 and M_DATA=0xA5 after 2 edges; LEVEL goes 0,1,1; pop -> LEVEL=0, ALMOST_EMPTY=1.
- Fill with M_READY=0: push 0x00..0x10 (17 words) -> LEVEL=17, S_READY=0 after the 17th push, SRL_ADDR=15, ALMOST_FULL=1 from LEVEL=12. Then drain -> order 0x00..0x10 exact, one per cycle.
- Streaming: S_VALID=1 and M_READY=1 for 100 cycles with an incrementing pattern -> no bubbles after the 2-cycle fill, LEVEL constant, data in order, SRL_ADDR stable.
- Full boundary: at LEVEL=17 hold S_VALID=1 and pulse M_READY once -> exactly one push accepted on the following cycle; no loss or duplication.
- CLR mid-stream at LEVEL=9 with S_VALID=1 -> next cycle LEVEL=0, M_VALID=0, SRL_CE=0 during CLR; a later push 0x3C emerges as the first word.
- Async reset with LEVEL=5 mid-cycle -> M_VALID, S_READY and LEVEL go to 0 without a clock edge; after release the FIFO behaves as empty.
